// File: rtl/exec_pkg.sv
// Shared types and sizes for the SPI execution unit.
package exec_pkg;

    localparam int unsigned FRAME_BITS   = 72;
    localparam int unsigned RESULT_BITS  = 32;
    localparam int unsigned OP_BITS      = 4;
    localparam int unsigned RSV_BITS     = 4;
    localparam int unsigned PAYLOAD_BITS = FRAME_BITS - RSV_BITS;
    localparam int unsigned SHAMT_BITS   = 5;
    localparam int unsigned MUL_STEPS    = 32;
    localparam int unsigned STEP_BITS    = 5;
    localparam int unsigned CNT_BITS     = 7;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLT = 4'd5,
        OP_SLL = 4'd6,
        OP_SRL = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9
    } opcode_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RECV = 3'd1,
        EXEC = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_e;

endpackage

// File: rtl/exec_core.sv
// Compute core: single-cycle ALU/shifter and a 32-step shift-add multiplier.
module exec_core
    import exec_pkg::*;
#(
    parameter bit EN_ALU   = 1'b1,
    parameter bit EN_SHIFT = 1'b1,
    parameter bit EN_MUL   = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [OP_BITS-1:0]     op_i,
    input  logic [RESULT_BITS-1:0] a_i,
    input  logic [RESULT_BITS-1:0] b_i,
    output logic                   done_c_o,
    output logic [RESULT_BITS-1:0] result_c_o
);

    logic [SHAMT_BITS-1:0]  shamt;
    logic                   is_mul;
    logic [RESULT_BITS-1:0] alu_res;
    logic [RESULT_BITS-1:0] partial;

    logic                   run_q,    run_d;
    logic [STEP_BITS-1:0]   step_q,   step_d;
    logic [RESULT_BITS-1:0] acc_q,    acc_d;
    logic [RESULT_BITS-1:0] mcand_q,  mcand_d;
    logic [RESULT_BITS-1:0] mplier_q, mplier_d;

    assign shamt   = b_i[SHAMT_BITS-1:0];
    assign is_mul  = EN_MUL && (op_i == OP_MUL);
    assign partial = mplier_q[0] ? mcand_q : '0;

    // Single-cycle result; disabled groups and unknown opcodes yield zero.
    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_ADD: if (EN_ALU) alu_res = a_i + b_i;
            OP_SUB: if (EN_ALU) alu_res = a_i - b_i;
            OP_AND: if (EN_ALU) alu_res = a_i & b_i;
            OP_OR:  if (EN_ALU) alu_res = a_i | b_i;
            OP_XOR: if (EN_ALU) alu_res = a_i ^ b_i;
            OP_SLT: if (EN_ALU) alu_res = RESULT_BITS'($signed(a_i) < $signed(b_i));
            OP_SLL: if (EN_SHIFT) alu_res = a_i << shamt;
            OP_SRL: if (EN_SHIFT) alu_res = a_i >> shamt;
            OP_SRA: if (EN_SHIFT) alu_res = $unsigned($signed(a_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // Multiplier sequencing: first step on start, last step folded into done.
    always_comb begin
        run_d      = run_q;
        step_d     = step_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        done_c_o   = 1'b0;
        result_c_o = alu_res;
        if (!start_i) begin
            run_d    = 1'b0;
            step_d   = '0;
            acc_d    = '0;
            mcand_d  = '0;
            mplier_d = '0;
        end else if (!is_mul) begin
            done_c_o = 1'b1;
        end else if (!run_q) begin
            run_d    = 1'b1;
            step_d   = STEP_BITS'(1);
            acc_d    = b_i[0] ? a_i : '0;
            mcand_d  = {a_i[RESULT_BITS-2:0], 1'b0};
            mplier_d = {1'b0, b_i[RESULT_BITS-1:1]};
        end else if (step_q == STEP_BITS'(MUL_STEPS - 1)) begin
            done_c_o   = 1'b1;
            result_c_o = acc_q + partial;
            run_d      = 1'b0;
            step_d     = '0;
        end else begin
            step_d   = step_q + STEP_BITS'(1);
            acc_d    = acc_q + partial;
            mcand_d  = {mcand_q[RESULT_BITS-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[RESULT_BITS-1:1]};
        end
    end

    // Multiplier state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q    <= 1'b0;
            step_q   <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            run_q    <= run_d;
            step_q   <= step_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/spi_exec_unit.sv
// SPI-slave front end: receives a request frame, runs exec_core, returns a marker plus result.
module spi_exec_unit
    import exec_pkg::*;
#(
    parameter bit EN_ALU   = 1'b1,
    parameter bit EN_SHIFT = 1'b1,
    parameter bit EN_MUL   = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic busy
);

    state_e                  state_q, state_d;
    logic                    sclk_q;
    logic [CNT_BITS-1:0]     cnt_q,   cnt_d;
    logic [PAYLOAD_BITS-1:0] frame_q, frame_d;
    logic [RESULT_BITS-1:0]  res_q,   res_d;
    logic                    miso_q,  miso_d;
    logic                    busy_q,  busy_d;

    logic                    rise_c;
    logic                    fall_c;
    logic                    rsv_bit_c;
    logic                    core_done_c;
    logic [RESULT_BITS-1:0]  core_result_c;

    assign rise_c    = sclk & ~sclk_q;
    assign fall_c    = ~sclk & sclk_q;
    assign rsv_bit_c = (cnt_q >= CNT_BITS'(OP_BITS)) && (cnt_q < CNT_BITS'(OP_BITS + RSV_BITS));
    assign miso      = miso_q;
    assign busy      = busy_q;

    exec_core #(
        .EN_ALU   (EN_ALU),
        .EN_SHIFT (EN_SHIFT),
        .EN_MUL   (EN_MUL)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .start_i    (state_q == EXEC),
        .op_i       (frame_q[PAYLOAD_BITS-1 -: OP_BITS]),
        .a_i        (frame_q[2*RESULT_BITS-1 -: RESULT_BITS]),
        .b_i        (frame_q[RESULT_BITS-1:0]),
        .done_c_o   (core_done_c),
        .result_c_o (core_result_c)
    );

    // Frame FSM: next state, shift registers and miso/busy next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        res_d   = res_q;
        miso_d  = miso_q;
        case (state_q)
            IDLE: begin
                miso_d  = 1'b0;
                cnt_d   = '0;
                frame_d = '0;
                if (!cs_n) state_d = RECV;
            end
            RECV: begin
                if (rise_c) begin
                    // Reserved bits are counted but never stored.
                    if (!rsv_bit_c) frame_d = {frame_q[PAYLOAD_BITS-2:0], mosi};
                    cnt_d = cnt_q + CNT_BITS'(1);
                    if (cnt_q == CNT_BITS'(FRAME_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                if (fall_c) miso_d = 1'b0;
                if (core_done_c) begin
                    res_d   = core_result_c;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (fall_c) begin
                    cnt_d = cnt_q + CNT_BITS'(1);
                    if (cnt_q == '0) begin
                        miso_d = 1'b1;
                    end else begin
                        miso_d = res_q[RESULT_BITS-1];
                        res_d  = {res_q[RESULT_BITS-2:0], 1'b0};
                    end
                    if (cnt_q == CNT_BITS'(RESULT_BITS)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (fall_c) miso_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Deselect mid-transaction throws everything away.
        if (state_q != IDLE && cs_n) begin
            state_d = IDLE;
            cnt_d   = '0;
            frame_d = '0;
            res_d   = '0;
            miso_d  = 1'b0;
        end
    end

    assign busy_d = (state_d == EXEC);

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sclk_q  <= 1'b0;
            cnt_q   <= '0;
            frame_q <= '0;
            res_q   <= '0;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sclk_q  <= sclk;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            res_q   <= res_d;
            miso_q  <= miso_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_exec_unit.sv
// Bench for spi_exec_unit: a full instance and an instance without the multiplier.
module tb_spi_exec_unit;

    localparam int H = 2;  // clocks per sclk half-period

    logic clock = 1'b0;
    logic reset;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso_f, busy_f;
    logic miso_n, busy_n;

    int vectors = 0;
    int errors  = 0;
    int busy_cnt_f = 0;

    always #5 clock = ~clock;

    spi_exec_unit #(.EN_ALU(1'b1), .EN_SHIFT(1'b1), .EN_MUL(1'b1)) u_full (
        .clock (clock), .reset (reset), .sclk (sclk), .cs_n (cs_n),
        .mosi (mosi), .miso (miso_f), .busy (busy_f)
    );

    spi_exec_unit #(.EN_ALU(1'b1), .EN_SHIFT(1'b1), .EN_MUL(1'b0)) u_nomul (
        .clock (clock), .reset (reset), .sclk (sclk), .cs_n (cs_n),
        .mosi (mosi), .miso (miso_n), .busy (busy_n)
    );

    // Running count of clocks with busy high on the full instance.
    always @(negedge clock) if (busy_f === 1'b1) busy_cnt_f <= busy_cnt_f + 1;

    // Reference: arithmetic straight from the opcode table.
    function automatic logic [31:0] model(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input bit en_mul);
        logic [31:0] r;
        logic [63:0] p;
        int sh;
        sh = int'(b % 32);
        r  = 32'd0;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6: begin r = a; repeat (sh) r = r * 2; end
            7: begin r = a; repeat (sh) r = r / 2; end
            8: begin r = a; repeat (sh) r = {r[31], r[31:1]}; end
            9: begin p = {32'd0, a} * {32'd0, b}; r = en_mul ? p[31:0] : 32'd0; end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // One sclk period: low half, sample miso as the master would, high half.
    task automatic sclk_cycle(input logic b, output logic mf, output logic mn);
        mosi = b;
        sclk = 1'b0;
        repeat (H) @(negedge clock);
        mf = miso_f;
        mn = miso_n;
        sclk = 1'b1;
        repeat (H) @(negedge clock);
    endtask

    task automatic send_bits(input int op, input logic [31:0] a, input logic [31:0] b, input int nbits);
        logic [71:0] f;
        logic mf, mn;
        f = {4'(op), 4'($urandom), a, b};
        for (int i = 0; i < nbits; i++) sclk_cycle(f[71-i], mf, mn);
    endtask

    // Wait for the marker (bounded), then collect 32 result bits.
    task automatic poll_result(input bit sel, input int nread, output logic [31:0] res, output bit got);
        logic mf, mn;
        got = 1'b0;
        res = 32'd0;
        for (int i = 0; i < 60 && !got; i++) begin
            sclk_cycle(1'b0, mf, mn);
            if ((sel ? mn : mf) === 1'b1) got = 1'b1;
        end
        if (got) begin
            for (int i = 0; i < nread; i++) begin
                sclk_cycle(1'b0, mf, mn);
                res = {res[30:0], (sel ? mn : mf)};
            end
        end
    endtask

    task automatic run_frame(input int op, input logic [31:0] a, input logic [31:0] b,
                             input bit sel, output logic [31:0] res, output bit got);
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        send_bits(op, a, b, 72);
        poll_result(sel, 32, res, got);
        cs_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1; cs_n = 1'b1; sclk = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({miso_f, busy_f} !== 2'b00) begin
            errors++;
            $display("FAIL reset_full: miso/busy=%b required 00", {miso_f, busy_f});
        end
        vectors++;
        if ({miso_n, busy_n} !== 2'b00) begin
            errors++;
            $display("FAIL reset_nomul: miso/busy=%b required 00", {miso_n, busy_n});
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    int unsigned d_op [9] = '{0, 1, 5, 6, 8, 7, 9, 9, 12};
    logic [31:0] d_a [9] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'd1, 32'h80000000,
                              32'h80000000, 32'd1234, 32'h00010000, 32'd5};
    logic [31:0] d_b [9] = '{32'd7, 32'd5, 32'd0, 32'd33, 32'd4, 32'd4,
                              32'd5678, 32'h00010000, 32'd7};
    logic [31:0] d_e [9] = '{32'h0000000C, 32'hFFFFFFFE, 32'd1, 32'd2, 32'hF8000000,
                              32'h08000000, 32'h006AE9BC, 32'd0, 32'd0};

    task automatic test_directed;
        logic [31:0] res;
        bit got;
        for (int i = 0; i < 9; i++) begin
            run_frame(int'(d_op[i]), d_a[i], d_b[i], 1'b0, res, got);
            vectors++;
            if (!got || res !== d_e[i]) begin
                errors++;
                $display("FAIL directed[%0d] op=%0d: got %h marker=%0d required %h",
                         i, d_op[i], res, got, d_e[i]);
            end
        end
    endtask

    task automatic test_busy;
        logic [31:0] res, a, b;
        bit got;
        int c0;
        a = $urandom; b = $urandom;
        c0 = busy_cnt_f;
        run_frame(9, a, b, 1'b0, res, got);
        vectors++;
        if (busy_cnt_f - c0 != 32) begin
            errors++;
            $display("FAIL busy_mul: busy clocks %0d required 32", busy_cnt_f - c0);
        end
        vectors++;
        if (!got || res !== model(9, a, b, 1'b1)) begin
            errors++;
            $display("FAIL busy_mul_result: got %h required %h", res, model(9, a, b, 1'b1));
        end
        c0 = busy_cnt_f;
        run_frame(4, a, b, 1'b0, res, got);
        vectors++;
        if (busy_cnt_f - c0 != 1) begin
            errors++;
            $display("FAIL busy_alu: busy clocks %0d required 1", busy_cnt_f - c0);
        end
    endtask

    task automatic test_disabled;
        logic [31:0] res;
        bit got;
        run_frame(9, 32'd1234, 32'd5678, 1'b1, res, got);
        vectors++;
        if (!got || res !== 32'd0) begin
            errors++;
            $display("FAIL nomul_op9: got %h marker=%0d required 00000000", res, got);
        end
        run_frame(0, 32'd5, 32'd7, 1'b1, res, got);
        vectors++;
        if (!got || res !== 32'h0000000C) begin
            errors++;
            $display("FAIL nomul_add: got %h marker=%0d required 0000000c", res, got);
        end
    endtask

    task automatic test_abort;
        logic [31:0] res;
        bit got;
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        send_bits(9, 32'hDEADBEEF, 32'h12345678, 40);
        cs_n = 1'b1;
        repeat (4) @(negedge clock);
        vectors++;
        if ({miso_f, busy_f} !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: miso/busy=%b required 00", {miso_f, busy_f});
        end
        run_frame(0, 32'd1, 32'd1, 1'b0, res, got);
        vectors++;
        if (!got || res !== 32'd2) begin
            errors++;
            $display("FAIL abort_next: got %h marker=%0d required 00000002", res, got);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        bit got;
        // Reset while shifting out an all-ones result.
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        send_bits(0, 32'hFFFFFFF0, 32'h0000000F, 72);
        poll_result(1'b0, 4, res, got);
        vectors++;
        if (!got || miso_f !== 1'b1) begin
            errors++;
            $display("FAIL send_pre_reset: miso=%b marker=%0d required 1", miso_f, got);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({miso_f, busy_f} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_send: miso/busy=%b required 00", {miso_f, busy_f});
        end
        cs_n = 1'b1; sclk = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        // Reset while the multiplier is running.
        cs_n = 1'b0;
        repeat (2) @(negedge clock);
        send_bits(9, 32'd3, 32'd4, 72);
        repeat (5) @(negedge clock);
        vectors++;
        if (busy_f !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_exec: busy=%b required 1", busy_f);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (busy_f !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_exec: busy=%b required 0", busy_f);
        end
        cs_n = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        run_frame(1, 32'd3, 32'd5, 1'b0, res, got);
        vectors++;
        if (!got || res !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL after_reset: got %h marker=%0d required fffffffe", res, got);
        end
    endtask

    task automatic test_random;
        logic [31:0] res, a, b, exp;
        bit got, sel;
        int op;
        for (int i = 0; i < 40; i++) begin
            op  = int'($urandom_range(0, 15));
            if (i % 5 == 0) op = 9;
            a   = $urandom;
            b   = (i % 3 == 0) ? ($urandom % 64) : $urandom;
            sel = (i % 4 == 3);
            exp = model(op, a, b, !sel);
            run_frame(op, a, b, sel, res, got);
            vectors++;
            if (!got || res !== exp) begin
                errors++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h inst=%0d: got %h marker=%0d required %h",
                         i, op, a, b, sel, res, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy();
        test_disabled();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: bench did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/spi_exec_unit.md
# spi_exec_unit

SPI-slave execution unit that receives an opcode and two 32-bit operands over a serial frame, computes an ALU, barrel-shift or multiply result, and shifts the 32-bit result back to the master. It sits behind the CPU's SPI master. It is instantiated three times, as the ALU, the multiplier and the barrel shifter, with parameters restricting each instance to its opcode group.

## Interface
- EN_ALU, default 1: accept opcodes 0–5.
- EN_SHIFT, default 1: accept opcodes 6–8.
- EN_MUL, default 1: accept opcode 9.
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- sclk  in  1  SPI clock from master, synchronous to clock.
- cs_n  in  1  chip select, active low.
- mosi  in  1  master data out.
- miso  out  1  slave data out; reset value 0.
- busy  out  1  high in EXEC; reset value 0.

## Operation
- Edge detection:
  - sclk is registered once into sclk_q.
  - rise = sclk & ~sclk_q.
  - fall = ~sclk & sclk_q.
  - Master guarantees each sclk half-period is at least 2 clocks.
- Request frame is 72 bits, MSB first, sampled on rise:
  - bits 71:68 opcode;
  - bits 67:64 reserved, ignored;
  - bits 63:32 operand A;
  - bits 31:0 operand B.
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLT: signed A<B gives 1, else 0.
  - 6 SLL: A<<B[4:0].
  - 7 SRL: A>>B[4:0].
  - 8 SRA: arithmetic A>>>B[4:0].
  - 9 MUL: low 32 bits of A×B, unsigned.
  - 10–15, or any opcode whose group is disabled: result 0.
- Arithmetic wraps modulo 2^32. Shift amount ignores B[31:5].
- States:
  - IDLE: miso=0. cs_n falling, or cs_n low, moves to RECV with bit count 0.
  - RECV: shift mosi in on each rise. After the 72nd bit, go to EXEC.
  - EXEC:
    - ALU and shift ops finish in 1 clock.
    - MUL is an iterative shift-add taking exactly 32 clocks.
    - Each fall in EXEC drives miso=0 (status "busy").
    - On completion, go to SEND.
  - SEND:
    - First fall drives miso=1 (start marker).
    - The next 32 falls drive result[31] down to result[0].
    - Then go to DONE.
  - DONE: miso=0 until cs_n is high, then IDLE.
- cs_n high in any non-IDLE state aborts: IDLE, miso=0, counters cleared, partial data discarded.
- Reset at any time causes the same abort, asynchronously.

## Timing
- miso changes 1 clock after the clock that detects fall. The master samples miso on the following sclk rise.
- Latency from 72nd rise to result ready:
  - ALU/shift: 1 clock.
  - MUL: 32 clocks.
- Master polling rule: keep toggling sclk after the request, discard 0 bits until the first 1, then read the next 32 bits.
- Minimum frame:
  - ALU/shift: 72 + 1 marker + 32 = 105 sclk cycles.
  - MUL: longer by the number of falls that occur during EXEC.
- busy rises the clock after the 72nd rise is detected. It falls the clock the result is registered.
- Reset values: state IDLE, miso 0, busy 0, all shift registers and counters 0.

## Structure
- Shared package exec_pkg holds:
  - the opcode enum (OP_ADD…OP_MUL);
  - the state enum (IDLE, RECV, EXEC, SEND, DONE);
  - localparams FRAME_BITS=72 and RESULT_BITS=32.
- One sub-module, exec_core:
  - combinational ALU/shifter plus the sequential 32-step multiplier;
  - start/done handshake;
  - parameters EN_ALU, EN_SHIFT, EN_MUL.
- The SPI front end and FSM live in spi_exec_unit.

## Test plan
- ADD 5,7 → marker then 0x0000000C; SUB 3,5 → 0xFFFFFFFE; SLT 0xFFFFFFFF,0 → 1.
- SLL 1 by 33 → 2; SRA 0x80000000 by 4 → 0xF8000000; SRL 0x80000000 by 4 → 0x08000000.
- MUL 1234×5678 → 0x006AE9BC; MUL 0x00010000×0x00010000 → 0; busy high exactly 32 clocks.
- Instance with EN_MUL=0, opcode 9 → 0; opcode 12 on a full instance → 0.
- cs_n raised after 40 bits, then a full ADD 1,1 frame → 2, with no residue from the aborted frame.
- reset asserted mid-SEND → miso 0 and busy 0 immediately; next frame completes normally.
